// File: rtl/clock_pkg.sv
// Shared clock-generator/meter encodings: duty codes and meter FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package clock_pkg;

  // Duty encoding shared with the programmable clock generators
  localparam logic [1:0] DUTY_25  = 2'd0;
  localparam logic [1:0] DUTY_50  = 2'd1;
  localparam logic [1:0] DUTY_75  = 2'd2;
  localparam logic [1:0] DUTY_ODD = 2'd3;

  // Meter FSM: waiting for the first rising edge, or timing a period
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MEAS = 1'b1
  } state_t;

endpackage

// File: rtl/clk_edge_det.sv
// Registers the measured clock (s1), delays it (s2), flags rising edges.
// Latency: rise and level are valid one clk after sig_in is sampled.
// Backpressure: none; free-running on every clk.
module clk_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic rise,
  output logic level
);

  logic s1;
  logic s2;

  // Two-stage sample of sig_in; s2 is the previous value of s1
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
    end
  end

  assign rise  = s1 & ~s2;
  assign level = s1;

endmodule

// File: rtl/clock_meter.sv
// Measures period and duty of a divided clock in generator encoding.
// Latency: meas_valid 2 clk after the first high sample of the closing edge.
// Backpressure: none; results are pulses, a missed pulse is simply lost.
module clock_meter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [1:0]       duty,
  output logic             meas_valid,
  output logic             stable,
  output logic             timeout
);

  import clock_pkg::*;

  // Wide enough that 4*hi and 3*tot never wrap
  localparam int WW = CNT_W + 2;
  localparam logic [CNT_W-1:0] TOT_MAX = {CNT_W{1'b1}};

  logic             rise;
  logic             level;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] tot, tot_nxt;
  logic [CNT_W-1:0] hi, hi_nxt;
  logic             publish;
  logic             expire;
  logic             have_prev;
  logic [1:0]       duty_new;
  logic [WW-1:0]    hi_w, tot_w, hi_x2, hi_x4, tot_x3;

  clk_edge_det u_edge (
    .clk    (clk),
    .rst    (rst),
    .sig_in (sig_in),
    .rise   (rise),
    .level  (level)
  );

  assign hi_w   = WW'(hi);
  assign tot_w  = WW'(tot);
  assign hi_x2  = hi_w << 1;
  assign hi_x4  = hi_w << 2;
  assign tot_x3 = (tot_w << 1) + tot_w;

  // Map the high-time/period ratio onto the generator duty codes
  always_comb begin
    duty_new = DUTY_ODD;
    if (hi_x4 == tot_w)       duty_new = DUTY_25;
    else if (hi_x2 == tot_w)  duty_new = DUTY_50;
    else if (hi_x4 == tot_x3) duty_new = DUTY_75;
  end

  // Next state and counters; a rise on the saturating cycle still publishes
  always_comb begin
    state_nxt = state;
    tot_nxt   = tot;
    hi_nxt    = hi;
    publish   = 1'b0;
    expire    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rise) begin
          state_nxt = ST_MEAS;
          tot_nxt   = CNT_W'(1);
          hi_nxt    = CNT_W'(1);
        end
      end
      ST_MEAS: begin
        if (rise) begin
          publish = 1'b1;
          tot_nxt = CNT_W'(1);
          hi_nxt  = CNT_W'(1);
        end else if (tot == TOT_MAX) begin
          expire    = 1'b1;
          state_nxt = ST_IDLE;
          tot_nxt   = '0;
          hi_nxt    = '0;
        end else begin
          tot_nxt = tot + CNT_W'(1);
          if (level) hi_nxt = hi + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        tot_nxt   = '0;
        hi_nxt    = '0;
      end
    endcase
  end

  // FSM state and period/high-time counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      tot   <= '0;
      hi    <= '0;
    end else begin
      state <= state_nxt;
      tot   <= tot_nxt;
      hi    <= hi_nxt;
    end
  end

  // Published results, pulses and stability tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      period     <= '0;
      duty       <= DUTY_25;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
      stable     <= 1'b0;
      have_prev  <= 1'b0;
    end else begin
      meas_valid <= publish;
      timeout    <= expire;
      if (publish) begin
        period    <= tot;
        duty      <= duty_new;
        stable    <= have_prev && (tot == period) && (duty_new == duty);
        have_prev <= 1'b1;
      end else if (expire) begin
        stable    <= 1'b0;
        have_prev <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_clock_meter.sv
// Directed table-driven check of clock_meter period/duty/stable/timeout.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_clock_meter;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             sig_in;
  logic [CNT_W-1:0] period;
  logic [1:0]       duty;
  logic             meas_valid;
  logic             stable;
  logic             timeout;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int overlap_cnt = 0;

  // Pulses captured by the monitor
  int               vcyc[$];
  logic [CNT_W-1:0] vper[$];
  logic [1:0]       vduty[$];
  logic             vstab[$];
  int               tcyc[$];

  typedef struct {
    int               hi;
    int               lo;
    logic [CNT_W-1:0] per;
    logic [1:0]       duty;
  } vec_t;

  vec_t vecs[9];

  always #5 clk = ~clk;

  clock_meter #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .sig_in     (sig_in),
    .period     (period),
    .duty       (duty),
    .meas_valid (meas_valid),
    .stable     (stable),
    .timeout    (timeout)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Record every output pulse, sampled away from the active edge
  always @(negedge clk) begin
    if (meas_valid && timeout) overlap_cnt = overlap_cnt + 1;
    if (meas_valid) begin
      vcyc.push_back(cyc);
      vper.push_back(period);
      vduty.push_back(duty);
      vstab.push_back(stable);
    end
    if (timeout) tcyc.push_back(cyc);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    sig_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drive(input int hi, input int lo);
    repeat (hi) begin
      sig_in = 1'b1;
      @(negedge clk);
    end
    repeat (lo) begin
      sig_in = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    int base;
    int tbase;

    vecs[0] = '{hi: 2, lo: 2,  per: 4'd4,  duty: 2'd1};
    vecs[1] = '{hi: 2, lo: 6,  per: 4'd8,  duty: 2'd0};
    vecs[2] = '{hi: 6, lo: 2,  per: 4'd8,  duty: 2'd2};
    vecs[3] = '{hi: 2, lo: 3,  per: 4'd5,  duty: 2'd3};
    vecs[4] = '{hi: 1, lo: 1,  per: 4'd2,  duty: 2'd1};
    vecs[5] = '{hi: 5, lo: 10, per: 4'd15, duty: 2'd3};
    vecs[6] = '{hi: 3, lo: 1,  per: 4'd4,  duty: 2'd2};
    vecs[7] = '{hi: 1, lo: 3,  per: 4'd4,  duty: 2'd0};
    vecs[8] = '{hi: 3, lo: 4,  per: 4'd7,  duty: 2'd3};

    rst    = 1'b1;
    sig_in = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_period",     int'(period),     0);
    check("reset_duty",       int'(duty),       0);
    check("reset_meas_valid", int'(meas_valid), 0);
    check("reset_stable",     int'(stable),     0);
    check("reset_timeout",    int'(timeout),    0);

    // Steady patterns: 3 full periods plus a closing rise -> 3 results
    for (int i = 0; i < 9; i++) begin
      do_reset();
      drive(0, 2);
      base  = vcyc.size();
      tbase = tcyc.size();
      for (int p = 0; p < 3; p++) drive(vecs[i].hi, vecs[i].lo);
      drive(1, 3);
      check($sformatf("v%0d_count", i), vcyc.size() - base, 3);
      check($sformatf("v%0d_timeouts", i), tcyc.size() - tbase, 0);
      if (vcyc.size() - base == 3) begin
        for (int k = 0; k < 3; k++) begin
          check($sformatf("v%0d_period%0d", i, k), int'(vper[base+k]), int'(vecs[i].per));
          check($sformatf("v%0d_duty%0d", i, k), int'(vduty[base+k]), int'(vecs[i].duty));
          check($sformatf("v%0d_stable%0d", i, k), int'(vstab[base+k]), (k == 0) ? 0 : 1);
          if (k > 0)
            check($sformatf("v%0d_gap%0d", i, k), vcyc[base+k] - vcyc[base+k-1], int'(vecs[i].per));
        end
      end
    end

    // Steady period 6, then stuck high -> one timeout 15 cycles after last result
    do_reset();
    drive(0, 2);
    base  = vcyc.size();
    tbase = tcyc.size();
    for (int p = 0; p < 3; p++) drive(3, 3);
    drive(20, 0);
    check("to_count_valid", vcyc.size() - base, 3);
    check("to_count_timeout", tcyc.size() - tbase, 1);
    if (tcyc.size() - tbase == 1 && vcyc.size() - base == 3)
      check("to_delay", tcyc[tbase] - vcyc[base+2], 15);
    check("to_hold_period", int'(period), 6);
    check("to_hold_duty",   int'(duty),   1);
    check("to_stable",      int'(stable), 0);
    base = vcyc.size();
    drive(0, 3);
    drive(3, 3);
    drive(1, 3);
    check("to_resume_count", vcyc.size() - base, 1);
    if (vcyc.size() - base == 1) begin
      check("to_resume_period", int'(vper[base]),  6);
      check("to_resume_duty",   int'(vduty[base]), 1);
      check("to_resume_stable", int'(vstab[base]), 0);
    end
    check("to_no_second_timeout", tcyc.size() - tbase, 1);

    // Reset in the middle of a period abandons it
    do_reset();
    drive(0, 2);
    for (int p = 0; p < 3; p++) drive(2, 2);
    drive(2, 1);
    check("mr_pre_period", int'(period), 4);
    check("mr_pre_stable", int'(stable), 1);
    base  = vcyc.size();
    tbase = tcyc.size();
    rst    = 1'b1;
    sig_in = 1'b0;
    @(negedge clk);
    check("mr_period",     int'(period),     0);
    check("mr_duty",       int'(duty),       0);
    check("mr_meas_valid", int'(meas_valid), 0);
    check("mr_stable",     int'(stable),     0);
    check("mr_timeout",    int'(timeout),    0);
    rst = 1'b0;
    drive(0, 20);
    check("mr_idle_low_no_pulse", (vcyc.size() - base) + (tcyc.size() - tbase), 0);
    drive(2, 2);
    check("mr_one_rise_no_valid", vcyc.size() - base, 0);
    drive(1, 3);
    check("mr_two_rise_count", vcyc.size() - base, 1);
    if (vcyc.size() - base == 1) begin
      check("mr_first_period", int'(vper[base]),  4);
      check("mr_first_duty",   int'(vduty[base]), 1);
      check("mr_first_stable", int'(vstab[base]), 0);
    end

    check("pulse_overlap", overlap_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
